// File: rtl/pipeline_debug_unit.sv
// Host debug controller: UART command bytes drive run/step/reset of the pipeline and a snapshot dump.
// Latency: command accepted at edge N acts in cycle N+1; the dump header follows step/halt one cycle later.
// Backpressure: tx_valid/tx_data hold until tx_ready; the dump stalls byte by byte with no data loss.
module pipeline_debug_unit #(
  parameter int NUM_WORDS = 16,
  parameter int SEL_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             halted,
  input  logic [31:0]      snap_data,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             pipe_enable,
  output logic             pipe_reset,
  output logic [SEL_W-1:0] snap_sel
);

  // Word 0 is the cycle counter, words 1..NUM_WORDS are snapshot words.
  localparam int               IDX_W     = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS);

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CMD_RST  = 8'h72;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_RST,
    ST_DUMP_HDR,
    ST_DUMP_LOAD,
    ST_DUMP_BYTE
  } state_t;

  // Position of the dump within the frame.
  typedef struct packed {
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
  } dump_ptr_t;

  state_t      state;
  state_t      state_nxt;
  dump_ptr_t   ptr;
  logic [31:0] cyc_cnt;
  logic [31:0] shift_q;
  logic        tx_xfer;
  logic        last_byte;
  logic        last_word;

  assign tx_xfer   = tx_valid & tx_ready;
  assign last_byte = (ptr.byte_idx == 2'd3);
  assign last_word = (ptr.word_idx == LAST_WORD);

  // State register; an async reset abandons any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: commands only decoded in IDLE, everything else is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RUN:  state_nxt = ST_RUN;
            CMD_STEP: state_nxt = ST_STEP;
            CMD_DUMP: state_nxt = ST_DUMP_HDR;
            CMD_RST:  state_nxt = ST_RST;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (halted) begin
          state_nxt = ST_DUMP_HDR;
        end
      end
      ST_STEP:      state_nxt = ST_DUMP_HDR;
      ST_RST:       state_nxt = ST_IDLE;
      ST_DUMP_HDR: begin
        if (tx_ready) begin
          state_nxt = ST_DUMP_LOAD;
        end
      end
      ST_DUMP_LOAD: state_nxt = ST_DUMP_BYTE;
      ST_DUMP_BYTE: begin
        if (tx_ready && last_byte) begin
          state_nxt = last_word ? ST_IDLE : ST_DUMP_LOAD;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; tx_data is forced to 0 whenever no byte is offered.
  always_comb begin
    pipe_enable = 1'b0;
    pipe_reset  = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    case (state)
      ST_RUN, ST_STEP: pipe_enable = ~halted;
      ST_RST:          pipe_reset  = 1'b1;
      ST_DUMP_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
      end
      ST_DUMP_BYTE: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[7:0];
      end
      default: ;
    endcase
  end

  // Cycle counter: counts enabled pipeline cycles, cleared by the reset command, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
    end else if (state == ST_RST) begin
      cyc_cnt <= '0;
    end else if (pipe_enable) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  // Dump datapath: LOAD captures a word, each accepted byte shifts it down; snap_sel leads the
  // capture by one word so the external mux has settled before LOAD samples it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      ptr      <= '0;
      snap_sel <= '0;
    end else begin
      case (state)
        ST_DUMP_LOAD: begin
          shift_q      <= (ptr.word_idx == '0) ? cyc_cnt : snap_data;
          ptr.byte_idx <= 2'd0;
        end
        ST_DUMP_BYTE: begin
          if (tx_xfer) begin
            shift_q      <= {8'h00, shift_q[31:8]};
            ptr.byte_idx <= ptr.byte_idx + 2'd1;
            if (last_byte) begin
              if (last_word) begin
                ptr.word_idx <= '0;
                snap_sel     <= '0;
              end else begin
                ptr.word_idx <= ptr.word_idx + IDX_W'(1);
                snap_sel     <= SEL_W'(ptr.word_idx);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_debug_unit.sv
module tb_pipeline_debug_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halted;
  logic [31:0] snap_data;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        pipe_enable;
  logic        pipe_reset;
  logic [3:0]  snap_sel;

  pipeline_debug_unit #(.NUM_WORDS(16), .SEL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .halted     (halted),
    .snap_data  (snap_data),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .pipe_enable(pipe_enable),
    .pipe_reset (pipe_reset),
    .snap_sel   (snap_sel)
  );

  always #5 clk = ~clk;

  // External snapshot mux model: word i reads 0x1000_0000 + i.
  assign snap_data = 32'h1000_0000 + 32'(snap_sel);

  typedef struct {
    logic [7:0] cmd;
    logic       hlt;
    bit         dump;
    int         en_d;
    int         rst_d;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         checks = 0;
  int         errors = 0;
  int         en_cnt = 0;
  int         rst_cnt = 0;
  int         hold_viol = 0;
  int         rx_total = 0;
  bit         bp_mode = 1'b0;
  int         bp_ph = 0;
  bit         mon_stall = 1'b0;
  logic [7:0] mon_held = 8'h00;
  logic [31:0] exp_cyc = 32'd0;

  // Monitor samples at the falling edge, between input changes and the next active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_stall = 1'b0;
      end else begin
        if (pipe_enable) en_cnt++;
        if (pipe_reset) rst_cnt++;
        if (mon_stall && (!tx_valid || tx_data != mon_held)) hold_viol++;
        mon_stall = tx_valid && !tx_ready;
        mon_held  = tx_data;
        if (tx_valid && tx_ready) begin
          rx_q.push_back(tx_data);
          rx_total++;
        end
      end
    end
  end

  // Transmitter ready: always 1, or 1 cycle on / 3 off in backpressure mode.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = bp_mode ? (bp_ph % 4 == 0) : 1'b1;
      bp_ph++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [31:0] cyc);
    logic [31:0] w;
    exp_q.push_back(8'hA5);
    for (int b = 0; b < 4; b++) exp_q.push_back(cyc[8*b +: 8]);
    for (int i = 0; i < 16; i++) begin
      w = 32'h1000_0000 + 32'(i);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // Drives one command byte; returns #1 after the accepting edge (cycle N+1).
  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk);
    #1;
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Pops received bytes against the expected queue until it empties or the bound expires.
  task automatic drain(input string name, input int bound);
    int n;
    logic [7:0] e;
    logic [7:0] a;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
        e = exp_q.pop_front();
        a = rx_q.pop_front();
        chk({name, "_byte"}, 32'(a), 32'(e));
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d bytes_missing required=0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_extra_bytes"}, 32'(rx_q.size()), 32'd0);
    chk({name, "_idle_sel"}, 32'(snap_sel), 32'd0);
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin
    int en0;
    int rst0;
    int r0;
    int n;

    vecs[0] = '{8'h64, 1'b0, 1'b1, 0, 0};
    vecs[1] = '{8'h73, 1'b0, 1'b1, 1, 0};
    vecs[2] = '{8'h73, 1'b0, 1'b1, 1, 0};
    vecs[3] = '{8'h73, 1'b0, 1'b1, 1, 0};
    vecs[4] = '{8'h73, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{8'h41, 1'b0, 1'b0, 0, 0};
    vecs[6] = '{8'h72, 1'b0, 1'b0, 0, 1};
    vecs[7] = '{8'h64, 1'b0, 1'b1, 0, 0};

    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halted   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_pipe_enable", 32'(pipe_enable), 32'd0);
    chk("rst_pipe_reset", 32'(pipe_reset), 32'd0);
    chk("rst_snap_sel", 32'(snap_sel), 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      halted = vecs[v].hlt;
      if (vecs[v].cmd == 8'h72) exp_cyc = 32'd0;
      else exp_cyc = exp_cyc + 32'(vecs[v].en_d);
      if (vecs[v].dump) push_frame(exp_cyc);
      en0  = en_cnt;
      rst0 = rst_cnt;
      send_cmd(vecs[v].cmd);
      case (vecs[v].cmd)
        8'h73: begin
          chk("vec_step_en", 32'(pipe_enable), 32'(!vecs[v].hlt));
          @(posedge clk);
          #1;
          chk("vec_step_hdr", {23'd0, tx_valid, tx_data}, 32'h1A5);
        end
        8'h64: chk("vec_dump_hdr", {23'd0, tx_valid, tx_data}, 32'h1A5);
        8'h72: chk("vec_rst_pulse", 32'(pipe_reset), 32'd1);
        default: chk("vec_unknown_quiet", {28'd0, tx_valid, pipe_enable, pipe_reset, 1'b0} | 32'(snap_sel), 32'd0);
      endcase
      if (vecs[v].dump) begin
        drain("vec_dump", 2000);
      end else begin
        repeat (4) @(posedge clk);
        #1;
        chk("vec_no_bytes", 32'(rx_q.size()), 32'd0);
      end
      chk("vec_en_cycles", 32'(en_cnt - en0), 32'(vecs[v].en_d));
      chk("vec_rst_pulses", 32'(rst_cnt - rst0), 32'(vecs[v].rst_d));
    end

    // Run until halted rises 10 cycles after acceptance; an 's' mid-run must be dropped.
    exp_cyc = exp_cyc + 32'd10;
    push_frame(exp_cyc);
    en0 = en_cnt;
    send_cmd(8'h63);
    chk("run_en_first", 32'(pipe_enable), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rx_data  = 8'h73;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    halted = 1'b1;
    #1;
    chk("run_en_halt_cycle", 32'(pipe_enable), 32'd0);
    @(posedge clk);
    #1;
    chk("run_hdr", {23'd0, tx_valid, tx_data}, 32'h1A5);
    drain("run_dump", 2000);
    chk("run_en_cycles", 32'(en_cnt - en0), 32'd10);
    halted = 1'b0;

    // Backpressure dump.
    bp_mode = 1'b1;
    r0 = hold_viol;
    push_frame(exp_cyc);
    send_cmd(8'h64);
    chk("bp_hdr_valid", 32'(tx_valid), 32'd1);
    drain("bp_dump", 2000);
    chk("bp_hold", 32'(hold_viol - r0), 32'd0);
    bp_mode = 1'b0;

    // Five steps, reset command, then dump reports zero.
    for (int s = 0; s < 5; s++) begin
      exp_cyc = exp_cyc + 32'd1;
      push_frame(exp_cyc);
      send_cmd(8'h73);
      drain("step5_dump", 2000);
    end
    rst0 = rst_cnt;
    send_cmd(8'h72);
    chk("rcmd_pulse", 32'(pipe_reset), 32'd1);
    @(posedge clk);
    #1;
    chk("rcmd_pulse_end", 32'(pipe_reset), 32'd0);
    chk("rcmd_pulse_count", 32'(rst_cnt - rst0), 32'd1);
    exp_cyc = 32'd0;
    push_frame(exp_cyc);
    send_cmd(8'h64);
    drain("rcmd_dump", 2000);

    // Async reset mid-frame.
    push_frame(32'd0);
    r0 = rx_total;
    send_cmd(8'h64);
    n = 0;
    while ((rx_total - r0) < 20 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("arst_reached_mid", 32'((rx_total - r0) >= 20), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_snap_sel", 32'(snap_sel), 32'd0);
    chk("arst_pipe_enable", 32'(pipe_enable), 32'd0);
    exp_q.delete();
    rx_q.delete();
    r0 = rx_total;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("arst_no_resume", 32'(rx_total - r0), 32'd0);
    chk("arst_idle_valid", 32'(tx_valid), 32'd0);
    push_frame(32'd0);
    send_cmd(8'h64);
    drain("arst_dump", 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
